dma_engine: RTL and testbench



---
 rtl/dma_engine.sv | 263 ++++++++++++++++++++++++++
 tb/tb_dma_engine.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_engine.sv
// Bus-mastering DMA between RAM and the IO sector window (0x80-0xFF).
// Ports: clk_i/rst_i; CPU regs cs/ioreq_n/wr_n/addr_i/data_i/data_o;
//   bus handshake busreq_n/busack_n; master bus m_addr, m_data_o/i,
//   m_oe, m_mreq_n, m_ioreq_n, m_rd_n, m_wr_n; done_o status level.
module dma_engine #(
    parameter int ACC_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cs,
    input  logic        ioreq_n,
    input  logic        wr_n,
    input  logic [2:0]  addr_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        busreq_n,
    input  logic        busack_n,
    output logic [15:0] m_addr,
    output logic [7:0]  m_data_o,
    input  logic [7:0]  m_data_i,
    output logic        m_oe,
    output logic        m_mreq_n,
    output logic        m_ioreq_n,
    output logic        m_rd_n,
    output logic        m_wr_n,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_RGAP,
        S_WR,
        S_WGAP,
        S_ADV,
        S_REL
    } state_t;

    localparam logic [3:0] ACC_LAST = 4'(ACC_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] mem_q, mem_d;
    logic [7:0]  port_q, port_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [3:0]  cyc_q, cyc_d;
    logic        dir_q, dir_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        abrt_q, abrt_d;
    logic        pend_q, pend_d;

    logic        reg_rd;
    logic        reg_wr;
    logic        ctrl_wr;
    logic        start;
    logic        abort;
    logic [7:0]  len_clip;
    logic [15:0] io_addr;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;

    assign reg_rd  = cs & ~ioreq_n;
    assign reg_wr  = reg_rd & ~wr_n;
    assign ctrl_wr = reg_wr & (addr_i == 3'd4);
    assign start   = ctrl_wr & data_i[0] & ~busy_q;
    assign abort   = ctrl_wr & data_i[2] & busy_q;

    // Zero and anything above 128 both mean a full 128-byte window.
    assign len_clip = (data_i == 8'd0 || data_i > 8'd128)
                    ? 8'd128 : data_i;

    // Port bit7 is forced on use so raw CPU values always hit the window.
    assign io_addr  = {8'h00, 1'b1, port_q[6:0]};
    assign src_addr = dir_q ? mem_q : io_addr;
    assign dst_addr = dir_q ? io_addr : mem_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            mem_q   <= '0;
            port_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            cyc_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abrt_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            port_q  <= port_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            cyc_q   <= cyc_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abrt_q  <= abrt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        port_d  = port_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        cyc_d   = cyc_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        done_d  = done_q;
        abrt_d  = abrt_q;
        pend_d  = pend_q;

        // Programming registers are frozen while a transfer runs.
        if (reg_wr && !busy_q) begin
            case (addr_i)
                3'd0: mem_d[7:0]  = data_i;
                3'd1: mem_d[15:8] = data_i;
                3'd2: port_d      = data_i;
                3'd3: begin
                    len_d = len_clip;
                    cnt_d = len_clip;
                end
                3'd4: dir_d = data_i[1];
                default: ;
            endcase
        end

        if (start) begin
            busy_d = 1'b1;
            done_d = 1'b0;
            abrt_d = 1'b0;
            cnt_d  = len_q;
        end

        if (abort) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!busack_n) begin
                    state_d = S_RD;
                    cyc_d   = '0;
                end
            end
            S_RD: begin
                if (cyc_q == ACC_LAST) begin
                    byte_d  = m_data_i;
                    state_d = S_RGAP;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            S_RGAP: begin
                state_d = S_WR;
                cyc_d   = '0;
            end
            S_WR: begin
                if (cyc_q == ACC_LAST) begin
                    state_d = S_WGAP;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            S_WGAP: begin
                state_d = S_ADV;
            end
            S_ADV: begin
                mem_d  = mem_q + 16'd1;
                port_d = {1'b1, port_q[6:0] + 7'd1};
                cnt_d  = cnt_q - 8'd1;
                // An abort landing on this very edge still stops here.
                if (cnt_q == 8'd1 || pend_q || abort) begin
                    state_d = S_REL;
                end else begin
                    state_d = S_RD;
                    cyc_d   = '0;
                end
            end
            S_REL: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                abrt_d  = pend_q;
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busreq_n  = 1'b1;
        m_addr    = '0;
        m_oe      = 1'b0;
        m_mreq_n  = 1'b1;
        m_ioreq_n = 1'b1;
        m_rd_n    = 1'b1;
        m_wr_n    = 1'b1;
        case (state_q)
            S_REQ: busreq_n = 1'b0;
            S_RD: begin
                busreq_n  = 1'b0;
                m_addr    = src_addr;
                m_mreq_n  = ~dir_q;
                m_ioreq_n = dir_q;
                m_rd_n    = 1'b0;
            end
            S_RGAP: begin
                busreq_n = 1'b0;
                m_addr   = src_addr;
            end
            S_WR: begin
                busreq_n  = 1'b0;
                m_addr    = dst_addr;
                m_oe      = 1'b1;
                m_mreq_n  = dir_q;
                m_ioreq_n = ~dir_q;
                m_wr_n    = 1'b0;
            end
            S_WGAP: begin
                busreq_n = 1'b0;
                m_addr   = dst_addr;
                m_oe     = 1'b1;
            end
            S_ADV: busreq_n = 1'b0;
            default: ;
        endcase
    end

    assign m_data_o = m_oe ? byte_q : 8'h00;
    assign done_o   = done_q;

    always_comb begin
        data_o = 8'h00;
        if (reg_rd) begin
            case (addr_i)
                3'd0: data_o = mem_q[7:0];
                3'd1: data_o = mem_q[15:8];
                3'd2: data_o = port_q;
                3'd3: data_o = cnt_q;
                3'd4: data_o = {5'b0, abrt_q, done_q, busy_q};
                default: data_o = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: CPU register access, bus grant
// model, memory/IO responder and access logging.
module tb_dma_engine;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cs = 1'b0;
    logic        ioreq_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [2:0]  addr_i = '0;
    logic [7:0]  data_i = '0;
    logic [7:0]  data_o;
    logic        busreq_n;
    logic        busack_n = 1'b1;
    logic [15:0] m_addr;
    logic [7:0]  m_data_o;
    logic [7:0]  m_data_i;
    logic        m_oe;
    logic        m_mreq_n;
    logic        m_ioreq_n;
    logic        m_rd_n;
    logic        m_wr_n;
    logic        done_o;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_cnt = 0;
    logic prv_rd = 1'b1;
    logic prv_wr = 1'b1;

    logic [15:0] rd_a[$];
    bit          rd_io[$];
    int          rd_t[$];
    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    bit          wr_io[$];

    dma_engine #(.ACC_CYCLES(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cs(cs),
        .ioreq_n(ioreq_n), .wr_n(wr_n), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o),
        .busreq_n(busreq_n), .busack_n(busack_n),
        .m_addr(m_addr), .m_data_o(m_data_o),
        .m_data_i(m_data_i), .m_oe(m_oe),
        .m_mreq_n(m_mreq_n), .m_ioreq_n(m_ioreq_n),
        .m_rd_n(m_rd_n), .m_wr_n(m_wr_n), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always_comb begin
        m_data_i = 8'h00;
        if (!m_ioreq_n) m_data_i = m_addr[7:0] + 8'h10;
        else if (!m_mreq_n) m_data_i = pat(m_addr);
    end

    // Grant model and access logger, all on the falling edge.
    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (busreq_n) begin
            busack_n = 1'b1;
            ack_cnt = 0;
        end else if (ack_cnt == 5) begin
            busack_n = 1'b0;
        end else begin
            ack_cnt = ack_cnt + 1;
        end
        if (!m_rd_n && prv_rd) begin
            rd_a.push_back(m_addr);
            rd_io.push_back(!m_ioreq_n);
            rd_t.push_back(cyc);
        end
        if (!m_wr_n && prv_wr) begin
            wr_a.push_back(m_addr);
            wr_d.push_back(m_data_o);
            wr_io.push_back(!m_ioreq_n);
        end
        prv_rd = m_rd_n;
        prv_wr = m_wr_n;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk_i);
        cs = 1'b1; ioreq_n = 1'b0; wr_n = 1'b0;
        addr_i = a; data_i = d;
        @(negedge clk_i);
        cs = 1'b0; ioreq_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk_i);
        cs = 1'b1; ioreq_n = 1'b0; wr_n = 1'b1; addr_i = a;
        #1 d = data_o;
        cs = 1'b0; ioreq_n = 1'b1;
    endtask

    task automatic clr_log();
        rd_a.delete(); rd_io.delete(); rd_t.delete();
        wr_a.delete(); wr_d.delete(); wr_io.delete();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_o; i++) @(negedge clk_i);
        #1;
        if (!done_o) chk("tmo_done", 32'(done_o), 32'd1);
    endtask

    task automatic wait_rd(input int n, input int budget);
        for (int i = 0; i < budget && rd_a.size() < n; i++)
            @(negedge clk_i);
        #1;
        if (rd_a.size() < n) chk("tmo_rd", rd_a.size(), n);
    endtask

    task automatic wait_wr(input int n, input int budget);
        for (int i = 0; i < budget && wr_a.size() < n; i++)
            @(negedge clk_i);
        #1;
        if (wr_a.size() < n) chk("tmo_wr", wr_a.size(), n);
    endtask

    task automatic prog(input logic [15:0] mem, input logic [7:0] port,
                        input logic [7:0] len, input logic [7:0] ctrl);
        cpu_wr(3'd0, mem[7:0]);
        cpu_wr(3'd1, mem[15:8]);
        cpu_wr(3'd2, port);
        cpu_wr(3'd3, len);
        cpu_wr(3'd4, ctrl);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic [7:0] lo;
        int bad;

        // 1: reset state
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        cpu_rd(3'd4, r);
        chk("rst_reg4", r, 8'h00);
        chk("rst_busreq", busreq_n, 1'b1);
        chk("rst_oe", m_oe, 1'b0);
        chk("rst_strb", {m_mreq_n, m_ioreq_n, m_rd_n, m_wr_n}, 4'hF);
        chk("rst_addr", m_addr, 16'h0000);
        chk("rst_done", done_o, 1'b0);

        // 2: IO -> mem, 4 bytes
        clr_log();
        prog(16'h4000, 8'h80, 8'd4, 8'h01);
        wait_done(400);
        chk("t2_nrd", rd_a.size(), 4);
        chk("t2_nwr", wr_a.size(), 4);
        for (int i = 0; i < 4 && i < rd_a.size(); i++) begin
            chk("t2_rda", rd_a[i], 16'h0080 + 16'(i));
            chk("t2_rdio", rd_io[i], 1'b1);
        end
        for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
            chk("t2_wra", wr_a[i], 16'h4000 + 16'(i));
            chk("t2_wrd", wr_d[i], 8'h90 + 8'(i));
            chk("t2_wrio", wr_io[i], 1'b0);
        end
        for (int i = 0; i + 1 < rd_t.size(); i++)
            chk("t2_gap", rd_t[i+1] - rd_t[i], 9);
        chk("t2_done", done_o, 1'b1);
        chk("t2_busreq", busreq_n, 1'b1);
        cpu_rd(3'd4, r);
        chk("t2_reg4", r, 8'h02);
        cpu_rd(3'd0, r);
        chk("t2_reg0", r, 8'h04);
        cpu_rd(3'd3, r);
        chk("t2_reg3", r, 8'h00);

        // 3: mem -> IO, 128 bytes with wrap
        clr_log();
        prog(16'hFFFE, 8'hFE, 8'd0, 8'h03);
        wait_done(2000);
        chk("t3_nwr", wr_a.size(), 128);
        chk("t3_nrd", rd_a.size(), 128);
        bad = 0;
        for (int i = 0; i < 128 && i < wr_a.size()
                        && i < rd_a.size(); i++) begin
            lo = 8'hFE + 8'(i);
            if (rd_a[i] !== 16'hFFFE + 16'(i)) bad++;
            if (rd_io[i] !== 1'b0) bad++;
            if (wr_a[i] !== {8'h00, 8'h80 | (lo & 8'h7F)}) bad++;
            if (wr_io[i] !== 1'b1) bad++;
            if (wr_d[i] !== pat(16'hFFFE + 16'(i))) bad++;
        end
        chk("t3_seq", bad, 0);
        if (rd_a.size() > 2) chk("t3_rd2", rd_a[2], 16'h0000);
        if (wr_a.size() > 2) chk("t3_wr2", wr_a[2], 16'h0080);
        cpu_rd(3'd0, r);
        chk("t3_reg0", r, 8'h7E);
        cpu_rd(3'd1, r);
        chk("t3_reg1", r, 8'h00);

        // 4: abort during byte 3 read
        clr_log();
        prog(16'h2000, 8'h90, 8'd10, 8'h01);
        wait_rd(3, 400);
        cpu_wr(3'd4, 8'h04);
        wait_done(400);
        repeat (20) @(negedge clk_i);
        chk("t4_nrd", rd_a.size(), 3);
        chk("t4_nwr", wr_a.size(), 3);
        chk("t4_busreq", busreq_n, 1'b1);
        cpu_rd(3'd4, r);
        chk("t4_reg4", r, 8'h06);
        cpu_rd(3'd3, r);
        chk("t4_reg3", r, 8'd7);

        // 5: writes while busy are ignored
        clr_log();
        prog(16'h3000, 8'h88, 8'd6, 8'h03);
        wait_rd(2, 400);
        cpu_wr(3'd4, 8'h01);
        cpu_wr(3'd0, 8'h34);
        cpu_wr(3'd1, 8'h12);
        wait_done(400);
        chk("t5_nrd", rd_a.size(), 6);
        chk("t5_nwr", wr_a.size(), 6);
        bad = 0;
        for (int i = 0; i < 6 && i < rd_a.size()
                        && i < wr_a.size(); i++) begin
            if (rd_a[i] !== 16'h3000 + 16'(i)) bad++;
            if (wr_a[i] !== 16'h0088 + 16'(i)) bad++;
            if (wr_io[i] !== 1'b1) bad++;
        end
        chk("t5_seq", bad, 0);
        cpu_rd(3'd4, r);
        chk("t5_reg4", r, 8'h02);
        cpu_rd(3'd1, r);
        chk("t5_reg1", r, 8'h30);

        // 6: reset during byte 2 write
        clr_log();
        prog(16'h5000, 8'h80, 8'd4, 8'h01);
        wait_wr(2, 400);
        chk("t6_inwr", m_wr_n, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("t6_wr", m_wr_n, 1'b1);
        chk("t6_oe", m_oe, 1'b0);
        chk("t6_busreq", busreq_n, 1'b1);
        chk("t6_strb", {m_mreq_n, m_ioreq_n, m_rd_n}, 3'b111);
        @(negedge clk_i);
        rst_i = 1'b0;
        cpu_rd(3'd4, r);
        chk("t6_reg4", r, 8'h00);
        cpu_rd(3'd0, r);
        chk("t6_reg0", r, 8'h00);
        repeat (20) @(negedge clk_i);
        chk("t6_nwr", wr_a.size(), 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
